cpu_control_unit: RTL and testbench
===================================

# cpu_control_unit

Multi-cycle control FSM that sits directly upstream of the CPU datapath. It owns the 13-bit program counter and sequences each instruction through fetch, decode, execute, memory and writeback. In each state it drives the datapath's memory strobes, operand-select, ALU-op and register-write controls. It consumes the datapath's opcode, branch-equal flag, branch target and the main memory's done handshake.

## Interface
- RESET_PC, 13'h0000, PC value loaded on reset
- TIMEOUT_CYCLES, 15, memory-wait watchdog limit; used only when the watchdog is compiled in
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- opcode  input  3  instruction opcode from the datapath decoder
- beq  input  1  datapath equality flag (operands equal)
- branch_target  input  13  branch destination from the datapath
- mem_done  input  1  main memory access complete
- read  output  1  memory read strobe
- write  output  1  memory write strobe
- instruction  output  1  1 = instruction fetch, 0 = data access
- instruction_type  output  1  1 = register operand to ALU, 0 = sign-extended immediate
- alu_op  output  3  ALU operation select
- write_flag  output  1  register-file write enable
- pc  output  13  current program counter
- halted  output  1  HALT executed
- fault  output  1  memory watchdog expired; held at 0 when the watchdog is compiled out

## Operation
- Opcode map:
  - 000 ADD, 001 SUB, 010 AND: R-type
  - 011 ADDI
  - 100 LOAD
  - 101 STORE
  - 110 BEQ
  - 111 HALT
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, FAULT.
- FETCH:
  - read=1, instruction=1.
  - Stay until mem_done=1 is sampled, then go to DECODE.
- DECODE: latch opcode into ir_op, then go to EXECUTE.
- EXECUTE:
  - alu_op: ir_op for ADD/SUB/AND; 000 for ADDI/LOAD/STORE; 001 for BEQ.
  - instruction_type=1 for R-type and BEQ, 0 otherwise.
  - Next state by ir_op:
    - R-type/ADDI: WRITEBACK.
    - LOAD/STORE: MEM.
    - BEQ: pc <= beq ? branch_target : pc+1, then FETCH.
    - HALT: HALT.
- MEM:
  - alu_op and instruction_type are held as in EXECUTE.
  - LOAD: read=1, instruction=0. STORE: write=1, instruction=0.
  - On mem_done: LOAD goes to WRITEBACK; STORE does pc <= pc+1 and goes to FETCH.
- WRITEBACK: write_flag=1 for exactly one cycle, alu_op held, pc <= pc+1, then FETCH.
- HALT: halted=1, all strobes 0; only reset exits.
- Control outputs are Moore, decoded from the state register and ir_op only, never from live inputs.
- read and write are never high together.
- PC arithmetic is 13-bit modulo: 13'h1FFF + 1 = 13'h0000.

## Timing
- Async reset (reset=0):
  - Immediately forces state=FETCH, pc=RESET_PC, ir_op=000.
  - All strobes and halted/fault = 0; this holds even mid-access.
- After reset deassertion, read=1 and instruction=1 are driven from the first cycle.
- mem_done is sampled on the rising edge and counts only while read or write is asserted.
- Strobes stay high until the edge that samples mem_done=1 and drop the next cycle.
- mem_done=1 in the first cycle of FETCH or MEM gives a 1-cycle access.
- Minimum instruction latency with 1-cycle memory:
  - R-type/ADDI: 4 cycles.
  - BEQ: 3.
  - STORE: 4.
  - LOAD: 5.
- beq and branch_target are sampled at the EXECUTE edge only.
- pc changes only on the exit edge of WRITEBACK, EXECUTE (BEQ) or MEM (STORE).

## Configuration
- CTRL_MEM_TIMEOUT_EN defined:
  - A 4-bit wait counter clears on entry to FETCH/MEM and increments each cycle without mem_done.
  - Once it reaches TIMEOUT_CYCLES, the FSM moves to FAULT: fault=1, all strobes 0, exit only by reset.
- CTRL_MEM_TIMEOUT_EN undefined:
  - No counter; the FSM waits for mem_done indefinitely.
  - fault is tied to 0.

## Test plan
- Reset and fetch: reset low, RESET_PC=13'h0010, release with mem_done tied 1 -> pc=0x010; read=1 and instruction=1 in cycle 1; DECODE in cycle 2.
- ADD sequence: opcode=000 -> alu_op=000, instruction_type=1; write_flag pulses once in cycle 4; pc 0x010 -> 0x011.
- LOAD with 3-cycle memory wait: mem_done delayed 3 cycles in MEM -> read=1 and instruction=0 held for 3 cycles; write_flag in the following cycle; 7 cycles total.
- BEQ: beq=1, branch_target=0x0AB -> pc=0x0AB after EXECUTE. Repeat with beq=0 -> pc+1.
- Wrap and HALT: pc=0x1FFF executing ADDI -> pc=0x0000. Then opcode=111 -> halted=1 and no strobes for 20 cycles.
- Reset mid-access and watchdog:
  - Assert reset during a MEM read -> read drops with no clock edge.
  - With CTRL_MEM_TIMEOUT_EN defined and mem_done held 0 -> fault=1 after 15 wait cycles; without the macro -> read stays 1.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM: owns the PC and drives datapath/memory controls per state.
// Optional memory watchdog compiled in with `define CTRL_MEM_TIMEOUT_EN.
module cpu_control_unit #(
    parameter logic [12:0] RESET_PC       = 13'h0000,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  opcode,
    input  logic        beq,
    input  logic [12:0] branch_target,
    input  logic        mem_done,
    output logic        read,
    output logic        write,
    output logic        instruction,
    output logic        instruction_type,
    output logic [2:0]  alu_op,
    output logic        write_flag,
    output logic [12:0] pc,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_HALT,
        ST_FAULT
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_ADDI  = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 4-bit wait counter (1..15)");
    end

    state_t      state_reg;
    logic [2:0]  ir_op_reg;
    logic [12:0] pc_reg;
    logic        waiting;
    logic        timeout;

    // FETCH and MEM are the only states that hold a memory strobe
    assign waiting = (state_reg == ST_FETCH) || (state_reg == ST_MEM);

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam logic [3:0] WAIT_LIMIT = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0] wait_cnt_reg;

    assign timeout = waiting && !mem_done && (wait_cnt_reg == WAIT_LIMIT);

    // Every path into FETCH/MEM comes from a state where this counter is cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg <= 4'd0;
        end else if (waiting && !mem_done) begin
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
        end else begin
            wait_cnt_reg <= 4'd0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_FETCH;
            pc_reg    <= RESET_PC;
            ir_op_reg <= 3'b000;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (mem_done) begin
                        state_reg <= ST_DECODE;
                    end else if (timeout) begin
                        state_reg <= ST_FAULT;
                    end
                end
                ST_DECODE: begin
                    ir_op_reg <= opcode;
                    state_reg <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    case (ir_op_reg)
                        OP_ADD, OP_SUB, OP_AND, OP_ADDI: state_reg <= ST_WRITEBACK;
                        OP_LOAD, OP_STORE:                state_reg <= ST_MEM;
                        OP_BEQ: begin
                            pc_reg    <= beq ? branch_target : pc_reg + 13'd1;
                            state_reg <= ST_FETCH;
                        end
                        default:                          state_reg <= ST_HALT;
                    endcase
                end
                ST_MEM: begin
                    if (mem_done) begin
                        if (ir_op_reg == OP_LOAD) begin
                            state_reg <= ST_WRITEBACK;
                        end else begin
                            pc_reg    <= pc_reg + 13'd1;
                            state_reg <= ST_FETCH;
                        end
                    end else if (timeout) begin
                        state_reg <= ST_FAULT;
                    end
                end
                ST_WRITEBACK: begin
                    pc_reg    <= pc_reg + 13'd1;
                    state_reg <= ST_FETCH;
                end
                ST_HALT:  state_reg <= ST_HALT;
                ST_FAULT: state_reg <= ST_FAULT;
                default:  state_reg <= ST_FETCH;
            endcase
        end
    end

    logic [2:0] exec_alu_op;
    logic       exec_reg_operand;

    always_comb begin
        exec_alu_op      = 3'b000;
        exec_reg_operand = 1'b0;
        case (ir_op_reg)
            OP_ADD, OP_SUB, OP_AND: begin
                exec_alu_op      = ir_op_reg;
                exec_reg_operand = 1'b1;
            end
            OP_BEQ: begin
                exec_alu_op      = 3'b001;
                exec_reg_operand = 1'b1;
            end
            default: begin
                exec_alu_op      = 3'b000;
                exec_reg_operand = 1'b0;
            end
        endcase
    end

    // Moore decode; reset masks it so strobes drop at once, even mid-access
    always_comb begin
        read             = 1'b0;
        write            = 1'b0;
        instruction      = 1'b0;
        instruction_type = 1'b0;
        alu_op           = 3'b000;
        write_flag       = 1'b0;
        halted           = 1'b0;
        if (reset) begin
            case (state_reg)
                ST_FETCH: begin
                    read        = 1'b1;
                    instruction = 1'b1;
                end
                ST_EXECUTE: begin
                    alu_op           = exec_alu_op;
                    instruction_type = exec_reg_operand;
                end
                ST_MEM: begin
                    alu_op           = exec_alu_op;
                    instruction_type = exec_reg_operand;
                    read             = (ir_op_reg == OP_LOAD);
                    write            = (ir_op_reg == OP_STORE);
                end
                ST_WRITEBACK: begin
                    alu_op           = exec_alu_op;
                    instruction_type = exec_reg_operand;
                    write_flag       = 1'b1;
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    assign fault = reset && (state_reg == ST_FAULT);
`else
    assign fault = 1'b0;
`endif

    assign pc = pc_reg;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: instruction sequences, branch, wrap, halt, reset and wait.
module tb_cpu_control_unit;

    logic        clk;
    logic        reset;
    logic [2:0]  opcode;
    logic        beq;
    logic [12:0] branch_target;
    logic        mem_done;
    logic        read;
    logic        write;
    logic        instruction;
    logic        instruction_type;
    logic [2:0]  alu_op;
    logic        write_flag;
    logic [12:0] pc;
    logic        halted;
    logic        fault;

    int n_checks = 0;
    int n_bad    = 0;

    cpu_control_unit #(
        .RESET_PC      (13'h0010),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .opcode          (opcode),
        .beq             (beq),
        .branch_target   (branch_target),
        .mem_done        (mem_done),
        .read            (read),
        .write           (write),
        .instruction     (instruction),
        .instruction_type(instruction_type),
        .alu_op          (alu_op),
        .write_flag      (write_flag),
        .pc              (pc),
        .halted          (halted),
        .fault           (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From the first FETCH cycle: one-cycle fetch, DECODE, land in EXECUTE
    task automatic fetch_decode(input logic [2:0] op);
        $display("instr op=%b pc=%h", op, pc);
        opcode   = op;
        mem_done = 1'b1;
        step();
        check("decode_no_read", {read, write, write_flag}, 3'b000);
        step();
    endtask

    initial begin
        int quiet_bad;
        int read_hi;
        reset         = 1'b0;
        opcode        = 3'b000;
        beq           = 1'b0;
        branch_target = 13'h0000;
        mem_done      = 1'b1;

        #12;
        check("rst_pc", pc, 13'h0010);
        check("rst_strobes", {read, write, write_flag, halted, fault}, 5'b0);
        reset = 1'b1;
        #1;
        check("fetch_c1", {read, instruction, write}, 3'b110);
        check("fetch_c1_pc", pc, 13'h0010);

        // ADD: 4 cycles, write_flag in cycle 4
        fetch_decode(3'b000);
        check("add_ex", {instruction_type, alu_op}, {1'b1, 3'b000});
        step();
        check("add_wb", {write_flag, pc}, {1'b1, 13'h0010});
        step();
        check("add_pc", {write_flag, read, pc}, {1'b0, 1'b1, 13'h0011});

        // SUB
        fetch_decode(3'b001);
        check("sub_ex", {instruction_type, alu_op}, {1'b1, 3'b001});
        step();
        check("sub_wb", {write_flag, alu_op}, {1'b1, 3'b001});
        step();
        check("sub_pc", pc, 13'h0012);

        // LOAD with memory answering in the third MEM cycle
        fetch_decode(3'b100);
        check("ld_ex", {instruction_type, alu_op}, {1'b0, 3'b000});
        mem_done = 1'b0;
        step();
        read_hi = 0;
        for (int k = 0; k < 3; k++) begin
            if (read && !instruction && !write) read_hi++;
            if (k == 2) mem_done = 1'b1;
            step();
        end
        check("ld_read_cycles", read_hi, 3);
        check("ld_wb", {write_flag, read}, 2'b10);
        step();
        check("ld_pc", {read, pc}, {1'b1, 13'h0013});

        // STORE
        fetch_decode(3'b101);
        step();
        check("st_mem", {write, read, instruction}, 3'b100);
        step();
        check("st_pc", {write, read, pc}, {2'b01, 13'h0014});

        // BEQ taken then not taken
        fetch_decode(3'b110);
        check("beq_ex", {instruction_type, alu_op, pc}, {1'b1, 3'b001, 13'h0014});
        beq = 1'b1;
        branch_target = 13'h00AB;
        step();
        check("beq_taken", {read, pc}, {1'b1, 13'h00AB});
        fetch_decode(3'b110);
        beq = 1'b0;
        branch_target = 13'h0155;
        step();
        check("beq_not_taken", pc, 13'h00AC);

        // Jump to the top of the PC range, then ADDI wraps it
        fetch_decode(3'b110);
        beq = 1'b1;
        branch_target = 13'h1FFF;
        step();
        check("beq_to_top", pc, 13'h1FFF);
        beq = 1'b0;
        fetch_decode(3'b011);
        check("addi_ex", {instruction_type, alu_op}, {1'b0, 3'b000});
        step();
        check("addi_wb", write_flag, 1'b1);
        step();
        check("addi_wrap", pc, 13'h0000);

        // HALT stays quiet for 20 cycles
        fetch_decode(3'b111);
        step();
        quiet_bad = 0;
        for (int k = 0; k < 20; k++) begin
            mem_done = k[0];
            if (!halted || read || write || write_flag || pc != 13'h0000) quiet_bad++;
            step();
        end
        check("halt_quiet", quiet_bad, 0);

        // Reset exits HALT and restarts from RESET_PC
        reset = 1'b0;
        #1;
        check("halt_rst", {halted, pc}, {1'b0, 13'h0010});
        #1;
        reset = 1'b1;
        #1;
        check("rst_refetch", read, 1'b1);

        // Reset in the middle of a LOAD memory read
        fetch_decode(3'b100);
        mem_done = 1'b0;
        step();
        check("mid_ld_read", read, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_ld_drop", {read, write, instruction, pc}, {3'b000, 13'h0010});
        #1;
        reset = 1'b1;
        #1;

        // Memory never answers during FETCH
        read_hi = 0;
        for (int k = 0; k < 15; k++) begin
            if (read && !fault) read_hi++;
            step();
        end
        check("wait_read_held", read_hi, 15);
`ifdef CTRL_MEM_TIMEOUT_EN
        check("wd_fault", {fault, read, write}, 3'b100);
`else
        check("wd_none", {fault, read}, 2'b01);
`endif
        step();
        check("wait_no_halt", halted, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
